// File: rtl/note_pkg.sv
// Shared definitions for the note scheduler: silent code, note count,
// scheduler state encodings (which double as the src output) and the demo ROM.
package note_pkg;

  localparam logic [3:0]  NOTE_SILENT = 4'hF;
  localparam int unsigned NOTE_COUNT  = 12;

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    LIVE   = 2'd1,
    HOLD   = 2'd2,
    DEMO   = 2'd3
  } sched_state_e;

  // Demo pattern: one octave up the major scale and back down.
  function automatic logic [3:0] demo_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    demo_rom = 4'd0;
      4'd1:    demo_rom = 4'd2;
      4'd2:    demo_rom = 4'd4;
      4'd3:    demo_rom = 4'd5;
      4'd4:    demo_rom = 4'd7;
      4'd5:    demo_rom = 4'd9;
      4'd6:    demo_rom = 4'd11;
      4'd7:    demo_rom = 4'd9;
      4'd8:    demo_rom = 4'd7;
      4'd9:    demo_rom = 4'd5;
      4'd10:   demo_rom = 4'd4;
      4'd11:   demo_rom = 4'd2;
      default: demo_rom = NOTE_SILENT;
    endcase
  endfunction

endpackage

// File: rtl/note_sched_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, never restarted
// except by reset. Shared with the bar driver.
module tick_gen #(
  parameter int unsigned TICK_DIV = 166667
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/note_sched.sv
// Note-source scheduler: live note wins, then a timed hold, then demo or silence.
// Demo sequencer is built only when NOTE_SCHED_DEMO_EN is defined.
module note_sched #(
  parameter int unsigned TICK_DIV   = 166667,
  parameter int unsigned HOLD_TICKS = 30,
  parameter int unsigned STEP_TICKS = 15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       live_valid,
  input  logic [3:0] live_note,
  input  logic       demo_en,
  output logic [3:0] note,
  output logic       note_valid,
  output logic [1:0] src
);

  import note_pkg::*;

  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  sched_state_e  state, state_nx;
  logic [3:0]    note_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic          tick;
  logic          live_ok;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  assign live_ok = (live_note < 4'(NOTE_COUNT));

`ifdef NOTE_SCHED_DEMO_EN
  localparam int unsigned SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(NOTE_COUNT - 1);

  logic [3:0]    idx, idx_nx;
  logic [SW-1:0] step, step_nx;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx  <= '0;
      step <= '0;
    end else begin
      idx  <= idx_nx;
      step <= step_nx;
    end
  end
`else
  logic unused_demo_en;
  assign unused_demo_en = demo_en;
`endif

  always_comb begin
    state_nx = state;
    note_nx  = note;
    hold_nx  = hold_cnt;
`ifdef NOTE_SCHED_DEMO_EN
    idx_nx   = idx;
    step_nx  = step;
`endif
    if (live_valid) begin
      state_nx = LIVE;
      note_nx  = live_ok ? live_note : NOTE_SILENT;
    end else begin
      case (state)
        LIVE: begin
          state_nx = HOLD;
          hold_nx  = '0;
        end
        HOLD: begin
          // demo_en is only consulted at expiry, so a mid-hold drop is deferred
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
`ifdef NOTE_SCHED_DEMO_EN
              if (demo_en) begin
                state_nx = DEMO;
                idx_nx   = '0;
                step_nx  = '0;
                note_nx  = demo_rom(4'd0);
              end else begin
                state_nx = SILENT;
                note_nx  = NOTE_SILENT;
              end
`else
              state_nx = SILENT;
              note_nx  = NOTE_SILENT;
`endif
            end else begin
              hold_nx = hold_cnt + 1'b1;
            end
          end
        end
`ifdef NOTE_SCHED_DEMO_EN
        DEMO: begin
          if (!demo_en) begin
            state_nx = SILENT;
            note_nx  = NOTE_SILENT;
          end else if (tick) begin
            if (step == STEP_LAST) begin
              step_nx = '0;
              idx_nx  = (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
            end else begin
              step_nx = step + 1'b1;
            end
            note_nx = demo_rom(idx_nx);
          end
        end
        SILENT: begin
          if (demo_en) begin
            state_nx = DEMO;
            idx_nx   = '0;
            step_nx  = '0;
            note_nx  = demo_rom(4'd0);
          end
        end
`endif
        default: begin
          state_nx = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= SILENT;
      note       <= NOTE_SILENT;
      note_valid <= 1'b0;
      src        <= 2'd0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nx;
      note       <= note_nx;
      note_valid <= (state_nx != SILENT);
      src        <= state_nx;
      hold_cnt   <= hold_nx;
    end
  end

endmodule

// File: tb/tb_note_sched.sv
// Scoreboard bench for note_sched at TICK_DIV=4, HOLD_TICKS=2, STEP_TICKS=1;
// expectations follow the build (NOTE_SCHED_DEMO_EN defined or not).
module tb_note_sched;

`ifdef NOTE_SCHED_DEMO_EN
  localparam bit D = 1'b1;
`else
  localparam bit D = 1'b0;
`endif

  typedef struct {
    int         id;
    logic [3:0] note;
    logic       valid;
    logic [1:0] src;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       live_valid = 1'b0;
  logic [3:0] live_note = 4'd0;
  logic       demo_en = 1'b0;
  logic [3:0] note;
  logic       note_valid;
  logic [1:0] src;

  exp_t exp_q[$];
  int   vec_id = 0;
  int   vectors_applied = 0;
  int   miscompares = 0;

  logic [3:0] rom [12] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd9,
                           4'd11, 4'd9, 4'd7, 4'd5, 4'd4, 4'd2};

  always #5 clk = ~clk;

  note_sched #(.TICK_DIV(4), .HOLD_TICKS(2), .STEP_TICKS(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .live_valid (live_valid),
    .live_note  (live_note),
    .demo_en    (demo_en),
    .note       (note),
    .note_valid (note_valid),
    .src        (src)
  );

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic vec(input logic r, input logic lv, input logic [3:0] ln, input logic de,
                     input logic [3:0] en, input logic ev, input logic [1:0] es);
    exp_t e;
    @(negedge clk);
    rstn       = r;
    live_valid = lv;
    live_note  = ln;
    demo_en    = de;
    e.id = vec_id;
    e.note = en;
    e.valid = ev;
    e.src = es;
    exp_q.push_back(e);
    vec_id++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors_applied++;
        if (note !== e.note || note_valid !== e.valid || src !== e.src) begin
          miscompares++;
          $display("FAIL vec%0d: got note=%h valid=%b src=%0d, want note=%h valid=%b src=%0d",
                   e.id, note, note_valid, src, e.note, e.valid, e.src);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // reset state and idle with demo disabled
    repeat (2) vec(0, 0, 4'd0, 0, 4'hF, 0, 2'd0);
    repeat (4) vec(1, 0, 4'd0, 0, 4'hF, 0, 2'd0);
    // live note 5 for ten cycles, then hold of two ticks, then silence
    repeat (10) vec(1, 1, 4'd5, 0, 4'd5, 1, 2'd1);
    repeat (5) vec(1, 0, 4'd0, 0, 4'd5, 1, 2'd2);
    repeat (3) vec(1, 0, 4'd0, 0, 4'hF, 0, 2'd0);
    // out-of-range live note, then a live pulse that cancels the hold
    vec(1, 1, 4'd13, 0, 4'hF, 1, 2'd1);
    repeat (2) vec(1, 0, 4'd0, 0, 4'hF, 1, 2'd2);
    vec(1, 1, 4'd3, 0, 4'd3, 1, 2'd1);
    repeat (5) vec(1, 0, 4'd0, 0, 4'd3, 1, 2'd2);
    repeat (2) vec(1, 0, 4'd0, 0, 4'hF, 0, 2'd0);
    // reset, then demo_en held high: full demo sweep with wrap
    vec(0, 0, 4'd0, 1, 4'hF, 0, 2'd0);
    for (int k = 1; k <= 49; k++)
      vec(1, 0, 4'd0, 1, D ? rom[(k / 4) % 12] : 4'hF, D, D ? 2'd3 : 2'd0);
    // one-cycle live pulse during demo; demo restarts at index 0 after the hold
    vec(1, 1, 4'd9, 1, 4'd9, 1, 2'd1);
    repeat (5) vec(1, 0, 4'd0, 1, 4'd9, 1, 2'd2);
    repeat (4) vec(1, 0, 4'd0, 1, D ? 4'd0 : 4'hF, D, D ? 2'd3 : 2'd0);
    vec(1, 0, 4'd0, 1, D ? 4'd2 : 4'hF, D, D ? 2'd3 : 2'd0);
    // demo_en drop leaves demo, raise re-enters fresh
    repeat (2) vec(1, 0, 4'd0, 0, 4'hF, 0, 2'd0);
    vec(1, 0, 4'd0, 1, D ? 4'd0 : 4'hF, D, D ? 2'd3 : 2'd0);
    vec(1, 0, 4'd0, 1, D ? 4'd2 : 4'hF, D, D ? 2'd3 : 2'd0);
    // demo_en falls during hold: expiry goes to silence
    vec(1, 1, 4'd7, 1, 4'd7, 1, 2'd1);
    repeat (6) vec(1, 0, 4'd0, 0, 4'd7, 1, 2'd2);
    vec(1, 0, 4'd0, 0, 4'hF, 0, 2'd0);
    // one-cycle reset in the middle of demo
    repeat (2) vec(1, 0, 4'd0, 1, D ? 4'd0 : 4'hF, D, D ? 2'd3 : 2'd0);
    vec(0, 0, 4'd0, 1, 4'hF, 0, 2'd0);
    repeat (3) vec(1, 0, 4'd0, 1, D ? 4'd0 : 4'hF, D, D ? 2'd3 : 2'd0);
    vec(1, 0, 4'd0, 1, D ? 4'd2 : 4'hF, D, D ? 2'd3 : 2'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/note_sched.md
# note_sched

Note-source scheduler ahead of the LED bar display. Arbitrates between a live note from the pitch detector and an internal demo sequence, and emits one registered 4-bit note stream. Live input always wins. After live input stops, the last note is held for a programmable time, then output falls back to the demo pattern or to silence. Output feeds the bar driver's `note` input directly.

## Interface
- `TICK_DIV`, 166667: clk cycles per scheduler tick (≥2).
- `HOLD_TICKS`, 30: ticks the last live note is held after `live_valid` drops (≥1).
- `STEP_TICKS`, 15: ticks per demo step (≥1).
- `clk` in 1: system clock.
- `rstn` in 1: reset; one clock; reset is synchronous and active-low.
- `live_valid` in 1: live note present this cycle.
- `live_note` in 4: live note index, 0–11 valid.
- `demo_en` in 1: demo fallback allowed (level, sampled every cycle).
- `note` out 4: scheduled note; 4'hF = silent.
- `note_valid` out 1: high unless in SILENT.
- `src` out 2: current state encoding (0 SILENT, 1 LIVE, 2 HOLD, 3 DEMO).

## Operation
- Reset: state SILENT, `note`=4'hF, `note_valid`=0, `src`=0, tick/hold/step counters and demo index 0.
- Tick: free-running counter 0..TICK_DIV-1; one-cycle `tick` pulse when count==TICK_DIV-1, then wraps to 0. The counter never restarts on state changes.
- Any state, `live_valid`=1 → LIVE. `note` <= `live_note` if ≤11, else 4'hF (state stays LIVE).
- LIVE, `live_valid`=0 → HOLD. `note` unchanged, hold counter cleared.
- HOLD: hold counter increments on tick. On a tick with hold==HOLD_TICKS-1, go to DEMO if `demo_en`, else SILENT.
- DEMO entry: index 0, step counter 0, `note`=ROM[0]. On a tick, the step counter increments. On a tick with step==STEP_TICKS-1, the step counter clears and the index advances, wrapping 11→0. `note`=ROM[index].
- DEMO, `demo_en`=0 → SILENT.
- SILENT, `demo_en`=1 → DEMO (fresh entry).
- Entering SILENT: `note`=4'hF.
- Demo ROM, 12 entries: 0,2,4,5,7,9,11,9,7,5,4,2.
- Priority within one cycle: `live_valid` > hold expiry > `demo_en` changes.

## Timing
- All outputs are registered. Input to `note`/`src` latency is 1 cycle.
- Hold duration from `live_valid` falling to leaving HOLD: between (HOLD_TICKS-1)·TICK_DIV+1 and HOLD_TICKS·TICK_DIV cycles, because tick phase is free-running.
- A live pulse of one cycle is sufficient to produce LIVE then HOLD on consecutive cycles.
- `live_valid` during HOLD cancels the hold. A later HOLD restarts its counter from 0.
- `demo_en` falling during HOLD has no effect until expiry. At expiry, state goes to SILENT.
- `rstn` low mid-operation returns every register to its reset value on the next edge.

## Configuration
- `NOTE_SCHED_DEMO_EN` defined: demo ROM, index and step counter are built in, behaving as above.
- `NOTE_SCHED_DEMO_EN` undefined:
  - no ROM or step logic is built, and `demo_en` is ignored;
  - HOLD expiry and all fallbacks go to SILENT;
  - `src` never reads 3.

## Structure
- Shared package `note_pkg` holds:
  - NOTE_SILENT = 4'hF and NOTE_COUNT = 12;
  - the state enum (SILENT/LIVE/HOLD/DEMO with the `src` encodings);
  - the demo ROM contents as a constant function.
- Sub-module `tick_gen` (parameter `TICK_DIV`; ports `clk`, `rstn`, `tick`) holds the prescaler. It is reusable by the bar driver.
- FSM, hold counter and demo sequencer live in the top module.

## Test plan
Bench uses TICK_DIV=4, HOLD_TICKS=2, STEP_TICKS=1.
- Reset release, `demo_en`=0, no live input → `note`=4'hF, `note_valid`=0, `src`=0 indefinitely.
- `live_valid`=1, `live_note`=5 for 10 cycles, then 0 → `note`=5 one cycle after assertion, `src`=1 then 2. `src`=0 and `note`=4'hF within 5–8 cycles of deassertion.
- `demo_en`=1 from reset → `src`=3 one cycle after the first post-reset cycle. `note` steps 0,2,4,5,7,9,11,9,7,5,4,2,0 every 4 cycles, wrapping.
- During DEMO, pulse `live_valid` one cycle with `live_note`=9 → `note`=9, `src`=1 for one cycle, then HOLD with `note`=9. DEMO resumes at index 0 after expiry.
- `live_note`=13 with `live_valid`=1 → `src`=1, `note`=4'hF, `note_valid`=1.
- `rstn` low for one cycle mid-DEMO → next cycle all outputs are at reset values. Build without `NOTE_SCHED_DEMO_EN`, `demo_en`=1 → `src` never equals 3.
